// File: rtl/oven_key_conditioner_if.sv
// Key conditioner signal bundle: raw pads and acks in, conditioned key events out.
interface oven_key_conditioner_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_ack;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_rpt;
    logic [N_KEYS-1:0] key_evt;
    logic [N_KEYS-1:0] key_ovf;

    // Consumer side: drives pads/acks, observes events.
    modport master (
        output key_raw, key_ack,
        input  key_level, key_press, key_rpt, key_evt, key_ovf
    );

    // Conditioner side.
    modport slave (
        input  key_raw, key_ack,
        output key_level, key_press, key_rpt, key_evt, key_ovf
    );
endinterface

// File: rtl/oven_key_conditioner.sv
// Oven keypad conditioner: per-key synchronizer, debouncer, press detector,
// auto-repeat FSM and sticky event/overflow flags for slow consumers.
module oven_key_conditioner #(
    parameter int                N_KEYS          = 4,
    parameter int                DEBOUNCE_CYCLES = 1000000,
    parameter int                REPEAT_DELAY    = 25000000,
    parameter int                REPEAT_RATE     = 5000000,
    parameter logic [N_KEYS-1:0] REPEAT_EN       = '1,
    parameter bit                KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    oven_key_conditioner_if.slave key_if
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Repeat counter holds the larger of the two reload values.
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam logic [RP_W-1:0] RP_DELAY_LD = RP_W'(REPEAT_DELAY);
    localparam logic [RP_W-1:0] RP_RATE_LD  = RP_W'(REPEAT_RATE);
    localparam logic [RP_W-1:0] RP_ONE      = RP_W'(1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    logic [N_KEYS-1:0] level_vec;
    logic [N_KEYS-1:0] press_vec;
    logic [N_KEYS-1:0] rpt_vec;
    logic [N_KEYS-1:0] evt_vec;
    logic [N_KEYS-1:0] ovf_vec;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        logic            pressed_raw;
        logic            sync1_q, sync2_q, smp_q;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        rpt_state_e      state_q, state_d;
        logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
        logic            rpt_q, rpt_d;
        logic            evt_q, evt_d;
        logic            ovf_q, ovf_d;
        logic            event_w;
        logic            ack_w;

        // Normalise polarity ahead of the synchronizer (a constant inversion),
        // so a reset synchronizer reads "not pressed".
        assign pressed_raw = key_if.key_raw[gi] ^ KEY_ACTIVE_LOW;
        assign event_w     = press_q | rpt_q;
        assign ack_w       = key_if.key_ack[gi];

        // Debounce: count cycles of disagreement, toggle level once stable long enough.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            press_d  = 1'b0;
            if (smp_q != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_d = ~level_q;
                    press_d = ~level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        // Repeat FSM: armed on the edge that raises key_press, counter expires at 1.
        always_comb begin
            state_d  = state_q;
            rp_cnt_d = rp_cnt_q;
            rpt_d    = 1'b0;
            case (state_q)
                RPT_IDLE: begin
                    rp_cnt_d = '0;
                    if (press_d && REPEAT_EN[gi]) begin
                        state_d  = RPT_DELAY;
                        rp_cnt_d = RP_DELAY_LD;
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (!level_q) begin
                        state_d  = RPT_IDLE;
                        rp_cnt_d = '0;
                    end else if (rp_cnt_q == RP_ONE) begin
                        rpt_d    = 1'b1;
                        state_d  = RPT_REPEAT;
                        rp_cnt_d = RP_RATE_LD;
                    end else begin
                        rp_cnt_d = rp_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d  = RPT_IDLE;
                    rp_cnt_d = '0;
                end
            endcase
        end

        // Sticky flags: a new event always wins over a same-cycle ack.
        always_comb begin
            evt_d = event_w | (evt_q & ~ack_w);
            ovf_d = (event_w & evt_q & ~ack_w) | (ovf_q & ~ack_w);
        end

        // All per-key state registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                smp_q    <= 1'b0;
                db_cnt_q <= '0;
                level_q  <= 1'b0;
                press_q  <= 1'b0;
                state_q  <= RPT_IDLE;
                rp_cnt_q <= '0;
                rpt_q    <= 1'b0;
                evt_q    <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                sync1_q  <= pressed_raw;
                sync2_q  <= sync1_q;
                smp_q    <= sync2_q;
                db_cnt_q <= db_cnt_d;
                level_q  <= level_d;
                press_q  <= press_d;
                state_q  <= state_d;
                rp_cnt_q <= rp_cnt_d;
                rpt_q    <= rpt_d;
                evt_q    <= evt_d;
                ovf_q    <= ovf_d;
            end
        end

        assign level_vec[gi] = level_q;
        assign press_vec[gi] = press_q;
        assign rpt_vec[gi]   = rpt_q;
        assign evt_vec[gi]   = evt_q;
        assign ovf_vec[gi]   = ovf_q;
    end

    assign key_if.key_level = level_vec;
    assign key_if.key_press = press_vec;
    assign key_if.key_rpt   = rpt_vec;
    assign key_if.key_evt   = evt_vec;
    assign key_if.key_ovf   = ovf_vec;

endmodule

// File: tb/tb_oven_key_conditioner.sv
// Directed bench for oven_key_conditioner with short debounce/repeat timings.
module tb_oven_key_conditioner;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    oven_key_conditioner_if #(.N_KEYS(N)) key_if ();

    oven_key_conditioner #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_EN       (4'b0011),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (key_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        logic [3:0] ack;
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] rpt;
        logic [3:0] evt;
        logic [3:0] ovf;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic r, input logic [3:0] raw, input logic [3:0] ack,
                                input logic [3:0] lv, input logic [3:0] pr, input logic [3:0] rp,
                                input logic [3:0] ev, input logic [3:0] ov);
        vec_t v;
        v.rst = r; v.raw = raw; v.ack = ack;
        v.level = lv; v.press = pr; v.rpt = rp; v.evt = ev; v.ovf = ov;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_if.key_raw = 4'b1111;
        key_if.key_ack = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Ticks until key_press[k] is seen; returns edge index (0 = first tick) or -1.
    task automatic wait_press(input int k, output int edge_idx);
        edge_idx = -1;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (key_if.key_press[k]) begin
                edge_idx = e;
                break;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        int press_cnt [4];
        int rpt_cnt   [4];
        int rise_edge;
        int press_edge;
        logic exp_r;

        key_if.key_raw = 4'b1111;
        key_if.key_ack = 4'b0000;

        // ---- Table: reset with keys held, then clean press on key 0 and ack ----
        vecs[0]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        vecs[1]  = mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 2; i <= 7; i++)
            vecs[i] = mk(1'b0, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        vecs[8]  = mk(1'b0, 4'b1110, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        vecs[9]  = mk(1'b0, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        vecs[10] = mk(1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        vecs[11] = mk(1'b0, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        vecs[12] = mk(1'b0, 4'b1110, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < 13; i++) begin
            rst            = vecs[i].rst;
            key_if.key_raw = vecs[i].raw;
            key_if.key_ack = vecs[i].ack;
            tick();
            $display("vec %0d: rst=%b raw=%b ack=%b -> level=%b press=%b rpt=%b evt=%b ovf=%b",
                     i, vecs[i].rst, vecs[i].raw, vecs[i].ack, key_if.key_level, key_if.key_press,
                     key_if.key_rpt, key_if.key_evt, key_if.key_ovf);
            check($sformatf("vec%0d_level", i), int'(key_if.key_level), int'(vecs[i].level));
            check($sformatf("vec%0d_press", i), int'(key_if.key_press), int'(vecs[i].press));
            check($sformatf("vec%0d_rpt",   i), int'(key_if.key_rpt),   int'(vecs[i].rpt));
            check($sformatf("vec%0d_evt",   i), int'(key_if.key_evt),   int'(vecs[i].evt));
            check($sformatf("vec%0d_ovf",   i), int'(key_if.key_ovf),   int'(vecs[i].ovf));
        end

        // ---- Bounce on key 1: low 3, high 2, then low and held ----
        do_reset();
        press_cnt[1] = 0;
        rise_edge = -1;
        press_edge = -1;
        for (int e = 0; e < 20; e++) begin
            key_if.key_raw = (e < 3 || e >= 5) ? 4'b1101 : 4'b1111;
            tick();
            if (key_if.key_press[1]) begin
                press_cnt[1]++;
                press_edge = e;
            end
            if (key_if.key_level[1] && rise_edge < 0) rise_edge = e;
        end
        $display("bounce: presses=%0d press_edge=%0d level_rise_edge=%0d", press_cnt[1], press_edge, rise_edge);
        check("bounce_press_count", press_cnt[1], 1);
        check("bounce_level_rise", rise_edge, 11);
        check("bounce_press_edge", press_edge, 11);

        // ---- Auto-repeat on key 0, raw released so level drops 30 cycles after press ----
        do_reset();
        key_if.key_raw = 4'b1110;
        wait_press(0, found);
        $display("repeat: press seen at edge %0d", found);
        check("repeat_press_edge", found, 6);
        for (int t = 1; t <= 45; t++) begin
            if (t == 24) key_if.key_raw = 4'b1111;
            tick();
            exp_r = (t >= 10 && t <= 28 && ((t - 10) % 3) == 0);
            if (key_if.key_rpt[0]) $display("repeat: rpt pulse at +%0d", t);
            check($sformatf("repeat_rpt_t%0d", t), int'(key_if.key_rpt[0]), int'(exp_r));
            check($sformatf("repeat_level_t%0d", t), int'(key_if.key_level[0]), (t < 30) ? 1 : 0);
            check($sformatf("repeat_nopress_t%0d", t), int'(key_if.key_press[0]), 0);
        end

        // ---- Handshake on key 2 (repeat masked off) ----
        do_reset();
        key_if.key_raw = 4'b1011;
        ticks(8);
        $display("hs: first press evt=%b ovf=%b", key_if.key_evt, key_if.key_ovf);
        check("hs_evt_first", int'(key_if.key_evt[2]), 1);
        check("hs_ovf_first", int'(key_if.key_ovf[2]), 0);
        key_if.key_raw = 4'b1111;
        ticks(8);
        check("hs_released", int'(key_if.key_level[2]), 0);
        check("hs_evt_held", int'(key_if.key_evt[2]), 1);
        key_if.key_raw = 4'b1011;
        ticks(7);
        check("hs_second_press", int'(key_if.key_press[2]), 1);
        tick();
        $display("hs: second press evt=%b ovf=%b", key_if.key_evt, key_if.key_ovf);
        check("hs_ovf_set", int'(key_if.key_ovf[2]), 1);
        check("hs_evt_still", int'(key_if.key_evt[2]), 1);
        key_if.key_ack = 4'b0100;
        tick();
        key_if.key_ack = 4'b0000;
        $display("hs: after ack evt=%b ovf=%b", key_if.key_evt, key_if.key_ovf);
        check("hs_ack_evt", int'(key_if.key_evt[2]), 0);
        check("hs_ack_ovf", int'(key_if.key_ovf[2]), 0);
        key_if.key_raw = 4'b1111;
        ticks(8);
        key_if.key_raw = 4'b1011;
        ticks(7);
        check("hs_third_press", int'(key_if.key_press[2]), 1);
        key_if.key_ack = 4'b0100;
        tick();
        key_if.key_ack = 4'b0000;
        $display("hs: ack with press evt=%b ovf=%b", key_if.key_evt, key_if.key_ovf);
        check("hs_setwins_evt", int'(key_if.key_evt[2]), 1);
        check("hs_setwins_ovf", int'(key_if.key_ovf[2]), 0);
        tick();
        check("hs_setwins_hold", int'(key_if.key_evt[2]), 1);

        // ---- Reset while key 0 is repeating ----
        do_reset();
        key_if.key_raw = 4'b1110;
        wait_press(0, found);
        check("rstmid_first_press", found, 6);
        ticks(12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("rstmid: during reset level=%b press=%b rpt=%b evt=%b ovf=%b",
                 key_if.key_level, key_if.key_press, key_if.key_rpt, key_if.key_evt, key_if.key_ovf);
        check("rstmid_level", int'(key_if.key_level), 0);
        check("rstmid_press", int'(key_if.key_press), 0);
        check("rstmid_rpt",   int'(key_if.key_rpt),   0);
        check("rstmid_evt",   int'(key_if.key_evt),   0);
        check("rstmid_ovf",   int'(key_if.key_ovf),   0);
        wait_press(0, found);
        $display("rstmid: fresh press at edge %0d after release", found);
        check("rstmid_fresh_press", found, 6);

        // ---- All keys held: mask disables repeat on keys 2/3, channels independent ----
        do_reset();
        key_if.key_raw = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            press_cnt[k] = 0;
            rpt_cnt[k]   = 0;
        end
        for (int e = 0; e < 47; e++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (key_if.key_press[k]) press_cnt[k]++;
                if (key_if.key_rpt[k])   rpt_cnt[k]++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            $display("mask: key%0d presses=%0d repeats=%0d", k, press_cnt[k], rpt_cnt[k]);
            check($sformatf("mask_press_k%0d", k), press_cnt[k], 1);
            check($sformatf("mask_rpt_k%0d", k), rpt_cnt[k], (k < 2) ? 11 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/oven_key_conditioner.md
OVEN_KEY_CONDITIONER -- requirements
Module: oven_key_conditioner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of clk.
REQ-002 Parameter N_KEYS, default 4, SHALL set the number of independent key channels.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the stable-input cycles required before the debounced level changes; the legal range is 2 or more.
REQ-004 Parameter REPEAT_DELAY, default 25000000, SHALL set the clk cycles from a press to the first auto-repeat; the legal range is 1 or more.
REQ-005 Parameter REPEAT_RATE, default 5000000, SHALL set the clk cycles between successive auto-repeats; the legal range is 1 or more.
REQ-006 Parameter REPEAT_EN, default all ones, SHALL be an N_KEYS-bit mask; bit i=1 enables auto-repeat on key i.
REQ-007 Parameter KEY_ACTIVE_LOW, default 1, SHALL mean the raw pad reads 0 when the key is pressed.
REQ-008 Port clk, input, 1 bit: system clock, 50 MHz.
REQ-009 Port rst, input, 1 bit: synchronous active-high reset.
REQ-010 Port key_raw, input, N_KEYS bits: asynchronous pushbutton pads.
REQ-011 Port key_ack, input, N_KEYS bits: consumer clears key_evt[i] and key_ovf[i].
REQ-012 Port key_level, output, N_KEYS bits: debounced pressed state, 1 = pressed.
REQ-013 Port key_press, output, N_KEYS bits: one-cycle pulse on a debounced press.
REQ-014 Port key_rpt, output, N_KEYS bits: one-cycle auto-repeat pulse.
REQ-015 Port key_evt, output, N_KEYS bits: sticky request flag, held until acknowledged, for slow-clocked consumers.
REQ-016 Port key_ovf, output, N_KEYS bits: sticky flag; a new event arrived while key_evt was still set.

Function
REQ-017 Each key_raw bit SHALL pass through a 2-flop synchronizer and then be polarity-normalized to 1 = pressed.
REQ-018 Per key, a debounce counter SHALL increment each cycle while the synchronized value differs from key_level, and SHALL clear to 0 on any cycle where the two are equal.
REQ-019 When the synchronized value still differs and the debounce counter equals DEBOUNCE_CYCLES-1, key_level SHALL toggle on the next edge and the counter SHALL clear.
REQ-020 A clean raw transition SHALL appear on key_level exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples the new raw value.
REQ-021 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no change on key_level.
REQ-022 key_press[i] SHALL be 1 for exactly the single cycle in which key_level[i] first reads 1; a release SHALL produce no pulse.
REQ-023 Each key SHALL have a repeat FSM with states IDLE, DELAY and REPEAT.
REQ-024 The repeat FSM SHALL go IDLE->DELAY on key_press and load its counter with REPEAT_DELAY.
REQ-025 In DELAY, when the counter expires, the FSM SHALL pulse key_rpt, enter REPEAT and load REPEAT_RATE.
REQ-026 In REPEAT, each counter expiry SHALL pulse key_rpt and reload REPEAT_RATE.
REQ-027 In any state, key_level=0 SHALL force IDLE on the next edge with no key_rpt pulse on that edge.
REQ-028 If REPEAT_EN[i]=0, key i SHALL remain in IDLE and key_rpt[i] SHALL stay 0.
REQ-029 key_evt[i] SHALL set on the cycle after key_press[i] or key_rpt[i] is 1, and SHALL clear on the cycle after key_ack[i] is 1; if set and ack occur in the same cycle, set SHALL win.
REQ-030 key_ovf[i] SHALL set when a press or repeat occurs while key_evt[i] is already 1 and no ack arrives in that cycle; key_ack[i] SHALL clear it, with set winning in the same cycle.
REQ-031 Each channel SHALL be fully independent; simultaneous activity on all keys SHALL be handled without interaction.
REQ-032 Counters SHALL be sized by ceiling-log2 of their parameter and SHALL never wrap.

Reset
REQ-033 While rst=1, the synchronizers, key_level, key_press, key_rpt, key_evt, key_ovf and all counters SHALL be 0, and every FSM SHALL be in IDLE, regardless of key_raw.
REQ-034 Reset asserted mid-press SHALL drop all outputs to 0; if the key is still held after rst releases, a fresh key_press SHALL follow DEBOUNCE_CYCLES+2 cycles later.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, KEY_ACTIVE_LOW=1)
REQ-035 Clean press: key_raw[0] 1->0 sampled at edge 0 -> key_level[0]=1 and a one-cycle key_press[0] after edge 6, and key_evt[0]=1 after edge 7.
REQ-036 Bounce: key_raw[1] toggles low for 3 cycles, high for 2, then low and held -> exactly one key_press[1], with key_level[1] rising 6 edges after the final low is sampled.
REQ-037 Auto-repeat: key 0 held for 30 cycles after key_press -> key_rpt pulses at +10, +13, +16, +19, +22, +25 and +28 cycles; release -> no further pulses and the FSM returns to IDLE.
REQ-038 Handshake: with key_evt[2]=1 and no ack, a second press on key 2 -> key_ovf[2]=1; key_ack[2] for one cycle -> both flags 0; ack coinciding with a press -> key_evt[2] stays 1.
REQ-039 Reset mid-repeat: rst=1 for 1 cycle while key 0 is in REPEAT -> all outputs 0 the next cycle; key still held -> key_press again 6 edges after reset release.
REQ-040 Mask: REPEAT_EN=4'b0011 with key 3 held for 40 cycles -> exactly one key_press[3] and key_rpt[3] constant 0.
